// File: rtl/prog_clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   DEFAULT_W   : default width of the divide ratio
//   DEFAULT_DIV : default ratio active after reset
//   MIN_DIV     : smallest legal divide ratio
//   state_e     : divider control states
`timescale 1ns/1ps
package prog_clk_div_pkg;

  localparam int unsigned DEFAULT_W   = 4;
  localparam int unsigned DEFAULT_DIV = 2;
  localparam int unsigned MIN_DIV     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/prog_clk_divider.sv
// Programmable clock divider producing a glitch-free registered divided clock.
// Ports:
//   clk_i     in   source clock
//   rst_n_i   in   asynchronous active-low reset
//   en_i      in   run request for the divided clock
//   load_i    in   single-cycle request to load div_i as the new ratio
//   div_i     in   requested divide ratio (legal 2..2^W-1)
//   div_clk_o out  divided clock, high for floor(R/2) of every R cycles
//   tick_o    out  one-cycle pulse in each cycle where div_clk_o rises
//   pend_o    out  a loaded ratio waits for the next period boundary
//   ratio_o   out  currently active ratio R
//   err_o     out  one-cycle pulse for a load request with an illegal ratio
// Ratio changes and stop requests only take effect at the period boundary
// (phase counter wrapping to 0), so no pulse is ever shortened.
`timescale 1ns/1ps
module prog_clk_divider
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned W       = DEFAULT_W,
  parameter int unsigned DEF_DIV = DEFAULT_DIV
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] div_i,
  output logic         div_clk_o,
  output logic         tick_o,
  output logic         pend_o,
  output logic [W-1:0] ratio_o,
  output logic         err_o
);

  state_e         state_r, state_s;
  logic [W-1:0]   cnt_r, cnt_s;
  logic [W-1:0]   ratio_r, ratio_s;
  logic [W-1:0]   shadow_r, shadow_s;
  logic           pend_r, pend_s;
  logic           div_clk_r, div_clk_s;
  logic           tick_r, tick_s;
  logic           err_r, err_s;
  logic           wrap_s;
  logic           legal_s;

  // Period boundary and load legality decode.
  always_comb begin
    wrap_s  = (cnt_r == (ratio_r - W'(1)));
    legal_s = load_i && (div_i >= W'(MIN_DIV));
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: leaving DRAIN for IDLE only at a period boundary.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = en_i ? RUN : IDLE;
      RUN:     state_s = en_i ? RUN : DRAIN;
      DRAIN: begin
        if (en_i) begin
          state_s = RUN;
        end else if (wrap_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cnt_s     = '0;
    ratio_s   = ratio_r;
    shadow_s  = shadow_r;
    pend_s    = pend_r;
    div_clk_s = 1'b0;
    tick_s    = 1'b0;
    err_s     = load_i && !legal_s;
    case (state_r)
      IDLE: begin
        // Nothing is running, so a legal ratio can take effect at once.
        if (legal_s) begin
          ratio_s  = div_i;
          shadow_s = div_i;
          pend_s   = 1'b0;
        end else begin
          ratio_s  = ratio_r;
        end
        if (en_i) begin
          div_clk_s = 1'b1;
          tick_s    = 1'b1;
        end else begin
          div_clk_s = 1'b0;
        end
      end
      RUN, DRAIN: begin
        if (wrap_s) begin
          cnt_s = '0;
          // The shadow captured before this edge becomes active here.
          if (pend_r) begin
            ratio_s = shadow_r;
            pend_s  = 1'b0;
          end else begin
            ratio_s = ratio_r;
          end
        end else begin
          cnt_s = cnt_r + W'(1);
        end
        // A load on the wrap edge itself waits for the following wrap.
        if (legal_s) begin
          shadow_s = div_i;
          pend_s   = 1'b1;
        end else begin
          shadow_s = shadow_s;
        end
        if (state_s == IDLE) begin
          div_clk_s = 1'b0;
          tick_s    = 1'b0;
        end else begin
          div_clk_s = (cnt_s < (ratio_s >> 1));
          tick_s    = (cnt_s == '0);
        end
      end
      default: begin
        cnt_s = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r     <= '0;
      ratio_r   <= W'(DEF_DIV);
      shadow_r  <= W'(DEF_DIV);
      pend_r    <= 1'b0;
      div_clk_r <= 1'b0;
      tick_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      ratio_r   <= ratio_s;
      shadow_r  <= shadow_s;
      pend_r    <= pend_s;
      div_clk_r <= div_clk_s;
      tick_r    <= tick_s;
      err_r     <= err_s;
    end
  end

  assign div_clk_o = div_clk_r;
  assign tick_o    = tick_r;
  assign pend_o    = pend_r;
  assign ratio_o   = ratio_r;
  assign err_o     = err_r;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider (W=4, DEF_DIV=2): directed steps
// followed by random traffic, compared against a period/phase reference model.
`timescale 1ns/1ps
module tb_prog_clk_divider;

  logic       clk;
  logic       rst_n_i;
  logic       en_i;
  logic       load_i;
  logic [3:0] div_i;
  logic       div_clk_o;
  logic       tick_o;
  logic       pend_o;
  logic [3:0] ratio_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  prog_clk_divider #(.W(4), .DEF_DIV(2)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n_i),
    .en_i     (en_i),
    .load_i   (load_i),
    .div_i    (div_i),
    .div_clk_o(div_clk_o),
    .tick_o   (tick_o),
    .pend_o   (pend_o),
    .ratio_o  (ratio_o),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: is a divided clock running, which phase of the period,
  // is a stop requested, active ratio, pending ratio.
  bit m_active, m_stop_req, m_pend, m_out, m_tick, m_err;
  int m_ph, m_r, m_sh;
  int hi_len;

  task automatic model_reset();
    m_active = 0; m_stop_req = 0; m_pend = 0;
    m_out = 0; m_tick = 0; m_err = 0;
    m_ph = 0; m_r = 2; m_sh = 2; hi_len = 0;
  endtask

  task automatic model_step(input bit en, input bit ld, input int dv);
    bit legal;
    bit at_end;
    bit stop;
    legal  = ld && (dv >= 2);
    at_end = m_active && (m_ph == m_r - 1);
    m_err  = ld && !legal;
    if (!m_active) begin
      if (legal) begin
        m_r = dv; m_sh = dv; m_pend = 0;
      end
      if (en) begin
        m_active = 1; m_stop_req = 0; m_ph = 0;
      end
    end else begin
      stop = m_stop_req && !en && at_end;
      if (at_end && m_pend) begin
        m_r = m_sh; m_pend = 0;
      end
      if (legal) begin
        m_sh = dv; m_pend = 1;
      end
      m_ph = at_end ? 0 : m_ph + 1;
      if (stop) m_active = 0;
      else      m_stop_req = !en;
    end
    m_out  = m_active && (m_ph < m_r / 2);
    m_tick = m_active && (m_ph == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("div_clk", {31'd0, div_clk_o}, {31'd0, m_out});
    chk("tick",    {31'd0, tick_o},    {31'd0, m_tick});
    chk("pend",    {31'd0, pend_o},    {31'd0, m_pend});
    chk("ratio",   {28'd0, ratio_o},   m_r);
    chk("err",     {31'd0, err_o},     {31'd0, m_err});
    // Every completed high pulse must last exactly floor(R/2) cycles.
    if (div_clk_o === 1'b1) begin
      hi_len++;
    end else begin
      if (hi_len != 0) chk("hi_width", hi_len, m_r / 2);
      hi_len = 0;
    end
  endtask

  task automatic step(input bit en, input bit ld, input logic [3:0] dv);
    en_i = en; load_i = ld; div_i = dv;
    @(posedge clk);
    model_step(en, ld, int'(dv));
    @(negedge clk);
    check_all();
    load_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n_i = 1'b0; en_i = 1'b0; load_i = 1'b0; div_i = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  initial begin
    int guard;
    bit en_r;
    int en_bias;
    rst_n_i = 1'b0; en_i = 1'b0; load_i = 1'b0; div_i = 4'd0;
    model_reset();

    // Reset values
    do_reset();
    chk("rst_ratio",  {28'd0, ratio_o}, 32'd2);
    chk("rst_divclk", {31'd0, div_clk_o}, 32'd0);
    chk("rst_pend",   {31'd0, pend_o}, 32'd0);
    step(1'b0, 1'b0, 4'd0);

    // R=2 run: first rise one cycle after en sampled, then toggling
    step(1'b1, 1'b0, 4'd0);
    chk("start_rise", {31'd0, div_clk_o}, 32'd1);
    chk("start_tick", {31'd0, tick_o}, 32'd1);
    repeat (7) step(1'b1, 1'b0, 4'd0);

    // Load 5 while running at R=2
    step(1'b1, 1'b1, 4'd5);
    chk("pend_set", {31'd0, pend_o}, 32'd1);
    repeat (12) step(1'b1, 1'b0, 4'd0);
    chk("ratio5", {28'd0, ratio_o}, 32'd5);

    // Load 7 then 3 within one period: only 3 applies
    guard = 0;
    while (m_ph != 0 && guard < 20) begin step(1'b1, 1'b0, 4'd0); guard++; end
    step(1'b1, 1'b1, 4'd7);
    step(1'b1, 1'b1, 4'd3);
    repeat (12) step(1'b1, 1'b0, 4'd0);
    chk("ratio3", {28'd0, ratio_o}, 32'd3);

    // R=6, drop en at cnt=1: finish period then idle
    step(1'b1, 1'b1, 4'd6);
    repeat (8) step(1'b1, 1'b0, 4'd0);
    guard = 0;
    while (m_ph != 1 && guard < 20) begin step(1'b1, 1'b0, 4'd0); guard++; end
    chk("ph1_reached", m_ph, 32'd1);
    repeat (10) step(1'b0, 1'b0, 4'd0);
    chk("idle_divclk", {31'd0, div_clk_o}, 32'd0);
    chk("idle_tick",   {31'd0, tick_o}, 32'd0);
    chk("idle_ratio",  {28'd0, ratio_o}, 32'd6);

    // Illegal loads: 1 then 0
    step(1'b0, 1'b1, 4'd1);
    chk("err_1", {31'd0, err_o}, 32'd1);
    step(1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd0);
    chk("err_0", {31'd0, err_o}, 32'd1);
    repeat (4) step(1'b1, 1'b0, 4'd0);

    // Random traffic with a varying enable bias
    en_bias = 9;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) en_bias = int'($urandom_range(1, 9));
      en_r = ($urandom_range(0, 9) < en_bias);
      step(en_r, ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-period with a load pending
    do_reset();
    repeat (3) step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd9);
    chk("pend_before_rst", {31'd0, pend_o}, 32'd1);
    @(posedge clk);
    #3 rst_n_i = 1'b0;
    #1;
    chk("arst_divclk", {31'd0, div_clk_o}, 32'd0);
    chk("arst_tick",   {31'd0, tick_o}, 32'd0);
    chk("arst_pend",   {31'd0, pend_o}, 32'd0);
    chk("arst_ratio",  {28'd0, ratio_o}, 32'd2);
    chk("arst_err",    {31'd0, err_o}, 32'd0);
    model_reset();
    en_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    repeat (3) step(1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    repeat (6) step(1'b1, 1'b0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk_i and rst_n_i.
REQ-002 Parameter W, default 4: width of the divide ratio.
REQ-003 Parameter DEF_DIV, default 2: active ratio after reset; legal range 2..2^W-1.
REQ-004 clk_i  input  1: source clock; every register samples on its rising edge.
REQ-005 rst_n_i  input  1: asynchronous active-low reset.
REQ-006 en_i  input  1: run request for the divided clock.
REQ-007 load_i  input  1: single-cycle request to load div_i as the new ratio.
REQ-008 div_i  input  W: requested divide ratio R; legal values are 2..2^W-1.
REQ-009 div_clk_o  output  1: registered divided clock; it feeds the downstream ripple counter's clk_i.
REQ-010 tick_o  output  1: one-cycle pulse in each cycle where div_clk_o rises.
REQ-011 pend_o  output  1: a loaded ratio is waiting for the next period boundary.
REQ-012 ratio_o  output  W: the currently active ratio R.
REQ-013 err_o  output  1: one-cycle pulse when load_i arrives with an illegal div_i.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-015 Internal phase counter cnt, range 0..R-1; it increments each cycle in RUN and DRAIN and wraps from R-1 to 0.
REQ-016 In RUN and DRAIN, div_clk_o SHALL be high when cnt < floor(R/2) and low otherwise; high time is floor(R/2) cycles and period is R cycles.
REQ-017 IDLE to RUN: when en_i is sampled high, on the same edge cnt becomes 0, div_clk_o becomes 1 and tick_o becomes 1.
REQ-018 RUN to DRAIN: when en_i is sampled low, the block SHALL complete the current period unchanged.
REQ-019 DRAIN to IDLE: at the edge where cnt wraps from R-1, cnt becomes 0 and div_clk_o stays 0.
REQ-020 DRAIN to RUN: if en_i is sampled high in DRAIN, return to RUN with no phase discontinuity.
REQ-021 In IDLE, div_clk_o, tick_o and cnt SHALL all be held at 0.
REQ-022 The block SHALL produce no high pulse shorter than floor(R/2) cycles and no low pulse shorter than R-floor(R/2) cycles, including at start, stop and ratio change.
REQ-023 Legal load_i in RUN or DRAIN: capture div_i into a shadow register and set pend_o; apply the shadow value at the next wrap to cnt=0, on the same edge that clears pend_o.
REQ-024 Legal load_i in IDLE: ratio_o updates on the next edge; pend_o stays 0.
REQ-025 A second legal load while pend_o is 1 SHALL overwrite the shadow register; only the last value is applied.
REQ-026 load_i on the same edge as a wrap SHALL be applied at the following wrap, not the current one.
REQ-027 Illegal div_i (0 or 1) with load_i: err_o pulses for one cycle, and the shadow register, pend_o and ratio_o are unchanged.
REQ-028 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-029 Reset values: state=IDLE, cnt=0, div_clk_o=0, tick_o=0, pend_o=0, err_o=0, ratio_o=DEF_DIV, shadow register=DEF_DIV.
REQ-030 Reset asserted mid-period SHALL force the reset values immediately; any pending load is discarded.
REQ-031 After reset release, the first div_clk_o rise SHALL come no earlier than one cycle after en_i is sampled high.

Structure
REQ-032 Package prog_clk_div_pkg SHALL hold the state enum (IDLE, RUN, DRAIN), the default W and DEF_DIV, and the constant MIN_DIV=2.
REQ-033 The block SHALL be a single module with no sub-module; the legality check and high-time compare are inline logic.

Verification
REQ-034 Reset, then en_i=1 with DEF_DIV=2 -> div_clk_o toggles every cycle, and tick_o pulses every 2 cycles starting one cycle after en_i.
REQ-035 Load div_i=5 while running at R=2 -> pend_o=1 until the next wrap; then ratio_o=5 and div_clk_o is high 2 cycles, low 3 cycles.
REQ-036 Load 7 then 3 within one period -> only 3 is applied at the wrap; no illegal-width pulse occurs.
REQ-037 Drop en_i at cnt=1 with R=6 -> div_clk_o completes its low phase, state becomes IDLE at the wrap, and outputs stay 0.
REQ-038 load_i with div_i=1, then with div_i=0 -> err_o pulses once per request; ratio_o and pend_o are unchanged.
REQ-039 Assert rst_n_i mid-period with pend_o=1 -> all outputs reset asynchronously and ratio_o=DEF_DIV; the downstream counter sees no extra edge.
